spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

SPI slave front end that sequences the on-chip 256x8 RAM. It deserialises MOSI frames into 10-bit RAM command words (`rx_data`/`rx_valid`). On a read-data command it captures the RAM's `dout`/`tx_valid` response and serialises it back on MISO. It sits between the chip SPI pins and the RAM command port, and is the only master of that port.

## Interface
- Parameters: none. Frame format is fixed: 10-bit command word, MSB first, and 8-bit read data, MSB first.
- `clk`  in  1  system clock; also the SPI bit clock, one bit per rising edge while `SS_n` is low.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SS_n`  in  1  slave select, active-low; high ends or aborts a frame.
- `MOSI`  in  1  serial data from master, sampled on rising `clk`.
- `MISO`  out  1  serial read data to master, registered.
- `rx_data`  out  10  command word to RAM: [9:8] opcode (00 wr addr, 01 wr data, 10 rd addr, 11 rd data), [7:0] payload.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  in  8  RAM read data.
- `tx_valid`  in  1  RAM response strobe; pulses after opcode 10 and opcode 11.

## Operation
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- **Internal flag `rd_addr_ok`:**
  - Set when a READ_ADD frame completes its 10th bit.
  - Cleared when the 8th MISO bit of a READ_DATA frame has been driven.
- **IDLE -> CHK_CMD:** on `SS_n`=0.
- **CHK_CMD:**
  - If `SS_n`=1, go to IDLE.
  - Otherwise sample `MOSI` as bit 9 into the shift register.
  - Bit 9 = 0 -> WRITE.
  - Bit 9 = 1 and `rd_addr_ok`=0 -> READ_ADD.
  - Bit 9 = 1 and `rd_addr_ok`=1 -> READ_DATA.
- **WRITE / READ_ADD / READ_DATA:**
  - Shift in bits 8..0, one per cycle.
  - On the 10th bit, load `rx_data` and pulse `rx_valid` for one cycle.
  - Further MOSI bits in the frame are ignored.
  - The word is forwarded unmodified; opcode bits are not checked. Example: 11 received in READ_ADD is still forwarded.
- **READ_DATA response:**
  - After its `rx_valid`, wait for `tx_valid`=1.
  - On `tx_valid`, capture `tx_data` into the output shift register and drive bits 7..0 on MISO, one per cycle.
  - Then drive MISO=0 and clear `rd_addr_ok`.
  - The wait has no timeout.
- **`tx_valid` outside READ_DATA:** ignored. This includes the pulse the RAM returns for opcode 10.
- **Return to IDLE:** from any non-IDLE state, `SS_n`=1 sampled -> IDLE on that edge.
- **Abort (`SS_n` high before the 10th bit):**
  - No `rx_valid` is issued.
  - Bit counter cleared.
  - MISO=0.
  - `rd_addr_ok` unchanged.
- **Abort during MISO shift-out:** stop, MISO=0, `rd_addr_ok` stays set so the master can retry the read.
- **Reset values:** state IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, `rd_addr_ok`=0, counters 0.
- **Reset mid-frame:** immediate return to reset values, regardless of state.

## Timing
Edges are numbered from E0, the first rising edge with `SS_n`=0 sampled in IDLE.
- **E0:** IDLE -> CHK_CMD.
- **E1:** `MOSI` sampled as bit 9; state -> WRITE / READ_ADD / READ_DATA.
- **E2..E10:** bits 8..0 sampled.
- **E10:** `rx_data` updated, `rx_valid`=1 during E10..E11; deasserted at E11.
- **RAM:** samples `rx_valid` at E11; `tx_valid` high during E11..E12.
- **E12 (READ_DATA only):**
  - `tx_valid` sampled and `tx_data` captured.
  - MISO = `tx_data`[7] from E12.
  - [6]..[0] at E13..E19.
- **E20:** MISO=0, `rd_addr_ok`=0.
- **Minimum frame length:** 11 edges for write/read-address, 20 edges for read-data, counted E0..E10 and E0..E19.
- **Consecutive frames:** `SS_n` must return high for at least 1 sampled cycle between frames.
- **Simultaneous events:** `SS_n` rising on the same edge as the 10th bit means the 10th bit is not taken and there is no `rx_valid`; IDLE wins.

## Test plan
- **Write address:** reset, then frame 00_0x2A -> `rx_valid` one cycle at E10, `rx_data`=0x02A; MISO stays 0.
- **Write data:** frame 01_0x5C -> `rx_data`=0x15C. Then read-address frame 10_0x2A -> `rx_data`=0x22A and `rd_addr_ok`=1; RAM `tx_valid` pulse ignored, MISO stays 0.
- **Read data:** frame 11_xx with RAM returning 0x5C at E11 -> MISO drives 0,1,0,1,1,1,0,0 on E12..E19, 0 at E20; `rd_addr_ok`=0, so the next read frame goes to READ_ADD.
- **Abort before 10th bit:** `SS_n` high after 6 bits of a write frame -> no `rx_valid`, state IDLE next edge; a following full frame 00_0x01 is received correctly.
- **Abort during shift-out:** `SS_n` high after 3 MISO bits -> MISO 0; `rd_addr_ok` still 1, so a retry frame 11_xx enters READ_DATA and returns the full byte.
- **Async reset:** `rst_n` low at E5 of a write frame -> all outputs 0 immediately; no `rx_valid` after release until a new full frame.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the 256x8 RAM: deserialises 10-bit command words from MOSI
// and, on a read-data command, returns the RAM byte MSB-first on MISO.
module spi_slave_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       MOSI,
   output logic       MISO,
   output logic [9:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK_CMD,
      S_WRITE,
      S_READ_ADD,
      S_READ_DATA
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [8:0]  sr_q, sr_d;
   logic [9:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        miso_q, miso_d;
   logic        rd_ok_q, rd_ok_d;
   logic [6:0]  tx_sr_q, tx_sr_d;
   logic [3:0]  tx_cnt_q, tx_cnt_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         sr_q       <= 9'd0;
         rx_data_q  <= 10'd0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         rd_ok_q    <= 1'b0;
         tx_sr_q    <= 7'd0;
         tx_cnt_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         rd_ok_q    <= rd_ok_d;
         tx_sr_q    <= tx_sr_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   // Next-state and output logic; tx_cnt: 0 wait for RAM, 1..8 shifting, 9 done
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sr_d       = sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = miso_q;
      rd_ok_d    = rd_ok_q;
      tx_sr_d    = tx_sr_q;
      tx_cnt_d   = tx_cnt_q;

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = 4'd0;
            tx_cnt_d  = 4'd0;
            miso_d    = 1'b0;
            if (!SS_n) begin
               state_d = S_CHK_CMD;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_CHK_CMD: begin
            if (SS_n) begin
               state_d   = S_IDLE;
               bit_cnt_d = 4'd0;
               miso_d    = 1'b0;
            end else begin
               sr_d      = {sr_q[7:0], MOSI};
               bit_cnt_d = 4'd1;
               if (!MOSI) begin
                  state_d = S_WRITE;
               end else if (rd_ok_q) begin
                  state_d = S_READ_DATA;
               end else begin
                  state_d = S_READ_ADD;
               end
            end
         end

         S_WRITE, S_READ_ADD, S_READ_DATA: begin
            // The last MISO bit was driven on the previous edge, even if SS_n rises now
            if (state_q == S_READ_DATA && tx_cnt_q == 4'd8) begin
               rd_ok_d = 1'b0;
            end else begin
               rd_ok_d = rd_ok_q;
            end

            if (SS_n) begin
               state_d   = S_IDLE;
               bit_cnt_d = 4'd0;
               tx_cnt_d  = 4'd0;
               miso_d    = 1'b0;
            end else if (bit_cnt_q != 4'd10) begin
               sr_d      = {sr_q[7:0], MOSI};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  rx_data_d  = {sr_q, MOSI};
                  rx_valid_d = 1'b1;
                  rd_ok_d    = rd_ok_d | (state_q == S_READ_ADD);
               end else begin
                  rx_data_d = rx_data_q;
               end
            end else if (state_q == S_READ_DATA) begin
               case (tx_cnt_q)
                  4'd0: begin
                     if (tx_valid) begin
                        tx_sr_d  = tx_data[6:0];
                        miso_d   = tx_data[7];
                        tx_cnt_d = 4'd1;
                     end else begin
                        miso_d = 1'b0;
                     end
                  end
                  4'd8: begin
                     miso_d   = 1'b0;
                     tx_cnt_d = 4'd9;
                  end
                  4'd9: begin
                     miso_d = 1'b0;
                  end
                  default: begin
                     miso_d   = tx_sr_q[6];
                     tx_sr_d  = {tx_sr_q[5:0], 1'b0};
                     tx_cnt_d = tx_cnt_q + 4'd1;
                  end
               endcase
            end else begin
               miso_d = 1'b0;
            end
         end

         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            tx_cnt_d  = 4'd0;
            miso_d    = 1'b0;
         end
      endcase
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised bench for spi_slave_ctrl: frames are described by command word, SS_n-low length
// and gap, and expected outputs are derived per edge from a frame-level model.
module tb_spi_slave_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int         total = 0;
   int         bad = 0;
   logic       rd_ok_m;
   logic [9:0] last_rx_m;

   spi_slave_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs for one edge, then check outputs 1 time unit after it
   task automatic step(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd,
                       input logic exp_rxv, input logic exp_miso);
      SS_n     = ss;
      MOSI     = mosi;
      tx_valid = txv;
      tx_data  = txd;
      @(posedge clk);
      #1;
      check_eq("rx_valid", 32'(rx_valid), 32'(exp_rxv));
      check_eq("rx_data", 32'(rx_data), 32'(last_rx_m));
      check_eq("MISO", 32'(MISO), 32'(exp_miso));
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
      check_eq("rst_rx_data", 32'(rx_data), 32'd0);
      check_eq("rst_MISO", 32'(MISO), 32'd0);
      rd_ok_m   = 1'b0;
      last_rx_m = 10'd0;
      SS_n      = 1'b1;
      tx_valid  = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // len = edges with SS_n low (E0..E(len-1)); SS_n high at E(len) plus gap-1 more edges
   task automatic run_frame(input logic [9:0] word, input int len, input logic [7:0] rbyte,
                            input int gap, input int rst_k);
      int kind;
      kind = 0;
      if (len >= 2) kind = !word[9] ? 1 : (rd_ok_m ? 3 : 2);
      for (int k = 0; k <= len; k++) begin
         logic       ss;
         logic       mosi;
         logic       txv;
         logic       emiso;
         logic [7:0] txd;
         ss   = (k < len) ? 1'b0 : 1'b1;
         mosi = (k >= 1 && k <= 10) ? word[10-k] : 1'($urandom_range(0, 1));
         txd  = 8'($urandom);
         txv  = 1'b0;
         if (k == 12 && word[9] && len >= 11) begin
            txv = 1'b1;
            txd = rbyte;
         end else if (kind == 1) begin
            txv = 1'($urandom_range(0, 1));
         end
         if (k == 10 && len >= 11) last_rx_m = word;
         emiso = (kind == 3 && k >= 12 && k <= 19 && k < len) ? rbyte[19-k] : 1'b0;
         step(ss, mosi, txv, txd, (k == 10 && len >= 11), emiso);
         if (k == rst_k) begin
            do_reset();
            return;
         end
      end
      if (len >= 11 && kind == 2) rd_ok_m = 1'b1;
      if (len >= 20 && kind == 3) rd_ok_m = 1'b0;
      for (int g = 1; g < gap; g++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      SS_n      = 1'b1;
      MOSI      = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'd0;
      rd_ok_m   = 1'b0;
      last_rx_m = 10'd0;
      #3;
      check_eq("por_rx_valid", 32'(rx_valid), 32'd0);
      check_eq("por_rx_data", 32'(rx_data), 32'd0);
      check_eq("por_MISO", 32'(MISO), 32'd0);
      #9;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

      // Directed sequence
      run_frame(10'h02A, 11, 8'h00, 1, -1);
      run_frame(10'h15C, 12, 8'h00, 2, -1);
      run_frame(10'h22A, 14, 8'h77, 1, -1);
      run_frame(10'h300, 21, 8'h5C, 1, -1);
      run_frame(10'h3FF, 11, 8'h00, 1, -1);
      run_frame(10'h0F3, 7, 8'h00, 1, -1);
      run_frame(10'h001, 11, 8'h00, 1, -1);
      run_frame(10'h3C3, 10, 8'h00, 1, -1);
      run_frame(10'h233, 11, 8'h00, 1, -1);
      run_frame(10'h300, 15, 8'hA5, 1, -1);
      run_frame(10'h300, 20, 8'hA5, 1, -1);
      run_frame(10'h0AB, 30, 8'h00, 1, 5);
      run_frame(10'h0CD, 11, 8'h00, 1, -1);
      run_frame(10'h211, 11, 8'h00, 1, -1);
      run_frame(10'h3EE, 25, 8'hFF, 1, 14);
      run_frame(10'h300, 19, 8'h81, 1, -1);

      // Random frames
      for (int f = 0; f < 80; f++) begin
         logic [9:0] w;
         int         len;
         int         r;
         int         rk;
         w    = 10'($urandom);
         w[9] = ($urandom_range(0, 2) != 0);
         r    = $urandom_range(0, 9);
         if (r < 2)      len = $urandom_range(1, 10);
         else if (r < 4) len = $urandom_range(11, 19);
         else            len = $urandom_range(20, 26);
         rk = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len) : -1;
         run_frame(w, len, 8'($urandom), $urandom_range(1, 3), rk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
